conv_enc_k3: RTL and testbench
==============================

// Module: conv_enc_k3
// PURPOSE
//  Rate-1/2, K=3 convolutional encoder (G0=7 octal/111b, G1=5 octal/101b). It is the transmit-side
//  counterpart of the Viterbi decoder, and its {g0,g1} pair matches the expected-symbol
//  convention of the decoder's branch-metric units. It accepts one bit per handshake and emits one
//  2-bit symbol per handshake. Frames are delimited by in_last, and the encoder state returns
//  to 00 at every frame boundary.
// PARAMETERS
//  CNT_W    16   width of the per-frame emitted-pair counter (frame_pairs)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      synchronous, active-low reset
//  in_valid     in   1      in_bit/in_last are valid
//  in_ready     out  1      encoder accepts the input this cycle
//  in_bit       in   1      information bit u
//  in_last      in   1      u is the final information bit of the frame
//  out_valid    out  1      out_pair/out_last are valid
//  out_ready    in   1      downstream accepts the output this cycle
//  out_pair     out  2      {g0,g1} coded symbol
//  out_last     out  1      final symbol of the frame
//  frame_pairs  out  CNT_W  symbols emitted in the last completed frame; held until the next frame completes
// BEHAVIOUR
//  - Reset (rst_n=0 at a posedge): sr=00, state=DATA, out_valid=0, out_pair=00, out_last=0,
//    frame_pairs=0, running count=0. A reset mid-frame discards the frame and any pending output.
//  - sr[1] is the most recent input and sr[0] is the one before it.
//    g0 = u^sr[1]^sr[0]; g1 = u^sr[0]; next sr = {u, sr[1]}.
//  - Output register "slot free" = !out_valid || out_ready, so full throughput is 1 symbol/clk.
//  - in_ready = (state==DATA) && slot free. An input is accepted on in_valid && in_ready.
//  - Latency: an accepted bit appears on out_pair on the next cycle.
//  - Backpressure: while out_valid && !out_ready, out_pair/out_last/out_valid hold stable.
//  - out_valid drops the cycle after a handshake if no new symbol is loaded.
//  - Running count increments on every output handshake and saturates at 2**CNT_W-1.
//    On the handshake with out_last=1, frame_pairs <= count+1 (saturating) and the count clears to 0.
//  - States: DATA, TAIL1, TAIL2 (TAIL states exist only with the macro enabled).
//    DATA  -> TAIL1 on accepting in_last=1.
//    TAIL1 -> TAIL2 when the slot is free; loads the symbol for u=0 with out_last=0.
//    TAIL2 -> DATA  when the slot is free; loads the symbol for u=0 with out_last=1, leaving sr=00.
//  - in_valid with in_ready=0 has no effect. Upstream must hold its data, and the encoder never drops a bit.
//  - A 1-bit frame (in_last on the first bit) is legal. Back-to-back frames need no idle cycle.
// CONFIGURATION
//  - CONV_ENC_TAIL_EN defined: zero-tail termination. Each frame of N bits emits N+2 symbols,
//    and out_last is on the second tail symbol. in_ready=0 during TAIL1/TAIL2.
//  - CONV_ENC_TAIL_EN undefined: no tail symbols and no TAIL states. The symbol for the in_last bit
//    carries out_last=1, and sr is forced to 00 when in_last is accepted. A frame of N bits emits N symbols.
// STRUCTURE
//  - Shared package viterbi_pkg holds:
//    - localparam K=3, G0=3'b111, G1=3'b101
//    - typedef logic [1:0] pair_t
//    - typedef enum logic [1:0] {ENC_DATA, ENC_TAIL1, ENC_TAIL2} enc_state_t
//  - One sub-module, conv_enc_step: combinational (u, sr) -> (pair, next_sr), built from the package
//    generators. The top level holds the handshake, FSM, output register and counters.
// TESTING
//  1. TAIL_EN, out_ready=1, bits 1,0,1,1(last).
//     Expect pairs 11,10,00,01,01,11 on consecutive cycles; out_last on the 6th; frame_pairs=6; sr=00.
//  2. TAIL_EN off, same bits.
//     Expect pairs 11,10,00,01; out_last on the 4th; frame_pairs=4. Then a bit 1 starts a new frame and emits 11.
//  3. Hold out_ready=0 for 5 cycles mid-frame.
//     Expect out_pair stable, in_ready=0, no bit lost or duplicated; the sequence matches case 1 afterwards.
//  4. 1-bit frame, bit 1(last), TAIL_EN.
//     Expect 11,10,11 with out_last on the 3rd and in_ready=0 during the tails. The next frame follows with no gap.
//  5. rst_n=0 for one cycle after 2 of 4 bits have been emitted.
//     Expect out_valid=0 and frame_pairs=0 next cycle. A bit 1 then yields 11 (sr was cleared).
//  6. Random 1000-bit frames with random valid/ready.
//     The reference-model encode matches, and a loopback through the Viterbi decoder returns the input bits.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 convolutional encoder / Viterbi decoder pair.
// Generator polynomials, the coded-symbol type, and the encoder FSM state type.
package viterbi_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef logic [1:0] pair_t;

    typedef enum logic [1:0] {
        ENC_DATA  = 2'b00,
        ENC_TAIL1 = 2'b01,
        ENC_TAIL2 = 2'b10
    } enc_state_t;

    // Generator output: parity of the taps selected by polynomial g.
    // taps is ordered {u, sr[1], sr[0]} so bit K-1 of g weights the newest bit.
    function automatic logic gen_bit(input logic [K-1:0] g, input logic [K-1:0] taps);
        return ^(g & taps);
    endfunction

endpackage

// File: rtl/conv_enc_step.sv
// One trellis step of the K=3 encoder: (u, sr) -> ({g0,g1}, next sr).
// Purely combinational; the generators come from viterbi_pkg.
module conv_enc_step
    import viterbi_pkg::*;
(
    input  logic         u,
    input  logic [K-2:0] sr,
    output pair_t        pair,
    output logic [K-2:0] next_sr
);

    logic [K-1:0] taps_s;

    // Build the tap vector, evaluate both generators, shift u into the register.
    always_comb begin
        taps_s  = {u, sr};
        pair    = {gen_bit(G0, taps_s), gen_bit(G1, taps_s)};
        next_sr = {u, sr[K-2]};
    end

endmodule

// File: rtl/conv_enc_k3.sv
// Rate-1/2, K=3 convolutional encoder with valid/ready handshakes on both sides.
// One information bit in, one {g0,g1} symbol out per handshake; frames delimited
// by in_last, encoder state returns to 00 at every frame boundary.
// Build option: define CONV_ENC_TAIL_EN for zero-tail termination (two extra
// u=0 symbols per frame). Without it, the in_last symbol closes the frame and
// the shift register is cleared directly.
module conv_enc_k3
    import viterbi_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_pair,
    output logic             out_last,
    output logic [CNT_W-1:0] frame_pairs
);

    logic [K-2:0]     sr_r;
    pair_t            out_pair_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] frame_pairs_r;

    logic             slot_free_s;
    logic             in_ready_s;
    logic             load_s;
    logic             load_last_s;
    logic             u_s;
    pair_t            step_pair_s;
    logic [K-2:0]     step_sr_s;
    logic [K-2:0]     sr_load_s;
    logic             out_hs_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // The output register can take a new symbol when empty or being drained.
    assign slot_free_s = !out_valid_r || out_ready;
    assign out_hs_s    = out_valid_r && out_ready;
    assign cnt_inc_s   = (count_r == {CNT_W{1'b1}}) ? count_r
                                                    : count_r + {{(CNT_W-1){1'b0}}, 1'b1};

    conv_enc_step u_step (
        .u       (u_s),
        .sr      (sr_r),
        .pair    (step_pair_s),
        .next_sr (step_sr_s)
    );

`ifdef CONV_ENC_TAIL_EN
    enc_state_t state_r;
    enc_state_t state_nxt_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ENC_DATA;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: enter the tail after the last data bit, leave after two tail symbols.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ENC_DATA: begin
                if (in_valid && slot_free_s && in_last) state_nxt_s = ENC_TAIL1;
                else                                    state_nxt_s = ENC_DATA;
            end
            ENC_TAIL1: begin
                if (slot_free_s) state_nxt_s = ENC_TAIL2;
                else             state_nxt_s = ENC_TAIL1;
            end
            ENC_TAIL2: begin
                if (slot_free_s) state_nxt_s = ENC_DATA;
                else             state_nxt_s = ENC_TAIL2;
            end
            default: state_nxt_s = ENC_DATA;
        endcase
    end

    // FSM outputs: input acceptance in DATA, forced u=0 symbols in the tail states.
    always_comb begin
        in_ready_s  = 1'b0;
        u_s         = 1'b0;
        load_s      = 1'b0;
        load_last_s = 1'b0;
        sr_load_s   = step_sr_s;
        case (state_r)
            ENC_DATA: begin
                in_ready_s = slot_free_s;
                u_s        = in_bit;
                load_s     = in_valid && slot_free_s;
            end
            ENC_TAIL1: begin
                load_s = slot_free_s;
            end
            ENC_TAIL2: begin
                load_s      = slot_free_s;
                load_last_s = 1'b1;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end
`else
    // Data-only operation: the in_last symbol ends the frame and clears the register.
    always_comb begin
        in_ready_s  = slot_free_s;
        u_s         = in_bit;
        load_s      = in_valid && slot_free_s;
        load_last_s = in_last;
        if (in_last) sr_load_s = {(K-1){1'b0}};
        else         sr_load_s = step_sr_s;
    end
`endif

    // Encoder shift register, advanced whenever a symbol is loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_r <= {(K-1){1'b0}};
        end else if (load_s) begin
            sr_r <= sr_load_s;
        end else begin
            sr_r <= sr_r;
        end
    end

    // Output register: load a new symbol, drain on handshake, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_pair_r  <= 2'b00;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_pair_r  <= step_pair_s;
            out_last_r  <= load_last_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Per-frame symbol counter; the total is published on the closing handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r       <= {CNT_W{1'b0}};
            frame_pairs_r <= {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            if (out_last_r) begin
                frame_pairs_r <= cnt_inc_s;
                count_r       <= {CNT_W{1'b0}};
            end else begin
                count_r <= cnt_inc_s;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_pair    = out_pair_r;
    assign out_last    = out_last_r;
    assign frame_pairs = frame_pairs_r;

endmodule

// File: tb/tb_conv_enc_k3.sv
// Directed bench for conv_enc_k3. Expected symbols are hand-computed for
// G0=111, G1=101; CONV_ENC_TAIL_EN selects the zero-tail expectations.
module tb_conv_enc_k3;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_pair;
    logic             out_last;
    logic [CNT_W-1:0] frame_pairs;

    int n_checks = 0;
    int n_fail   = 0;

    logic       bits_q[$];
    logic       last_q[$];
    logic [1:0] exp_pair[$];
    logic       exp_last[$];
    logic [1:0] obs_pair[$];
    logic       obs_last[$];
    int         obs_cyc[$];
    int         acc_cyc[$];
    int         exp_n;
    int         stall_bad;

    conv_enc_k3 #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bit      (in_bit),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pair    (out_pair),
        .out_last    (out_last),
        .frame_pairs (frame_pairs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 10ms)", $time);
        $fatal(1);
    end

    // Feed bits_q/last_q and record every output handshake. Starts and ends #1 after a posedge.
    // mode 0: always ready; 1: random valid/ready; 2: out_ready low for loop cycles 2..6.
    task automatic capture(input int mode, input int max_cyc);
        int idx = 0;
        int cyc = 0;
        logic [1:0] prev_pair = 2'b00;
        obs_pair.delete(); obs_last.delete(); obs_cyc.delete(); acc_cyc.delete();
        stall_bad = 0;
        while ((obs_pair.size() < exp_n) && (cyc < max_cyc)) begin
            if (idx < bits_q.size()) begin
                in_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                in_bit   = bits_q[idx];
                in_last  = last_q[idx];
            end else begin
                in_valid = 1'b0;
                in_bit   = 1'b0;
                in_last  = 1'b0;
            end
            if (mode == 1)      out_ready = 1'($urandom_range(0, 1));
            else if (mode == 2) out_ready = (cyc >= 2 && cyc < 7) ? 1'b0 : 1'b1;
            else                out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            if (out_valid && out_ready) begin
                obs_pair.push_back(out_pair);
                obs_last.push_back(out_last);
                obs_cyc.push_back(cyc);
            end
            if (mode == 2 && !out_ready) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || (cyc > 2 && out_pair !== prev_pair))
                    stall_bad++;
            end
            prev_pair = out_pair;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_pair !== 2'b00) begin n_fail++; $display("FAIL reset_out_pair: got %b want 00", out_pair); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_checks++; if (frame_pairs !== 16'd0) begin n_fail++; $display("FAIL reset_frame_pairs: got %0d want 0", frame_pairs); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_frame;
        bits_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef CONV_ENC_TAIL_EN
        exp_pair = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_pair = '{2'b11, 2'b10, 2'b00, 2'b01};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
        exp_n = exp_pair.size();
        capture(0, 200);
        n_checks++;
        if (obs_pair.size() != exp_n) begin
            n_fail++; $display("FAIL frame_count: got %0d symbols want %0d", obs_pair.size(), exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                n_checks++;
                if (obs_pair[i] !== exp_pair[i] || obs_last[i] !== exp_last[i] || obs_cyc[i] != i + 1) begin
                    n_fail++;
                    $display("FAIL frame_sym%0d: got pair %b last %b cyc %0d want %b %b %0d",
                             i, obs_pair[i], obs_last[i], obs_cyc[i], exp_pair[i], exp_last[i], i + 1);
                end
            end
        end
        n_checks++;
        if (frame_pairs !== 16'(exp_n)) begin n_fail++; $display("FAIL frame_pairs: got %0d want %0d", frame_pairs, exp_n); end
        // A new frame starting with bit 1 must see a cleared register.
        bits_q = '{1'b1};
        last_q = '{1'b1};
        exp_n = 1;
        capture(0, 50);
        n_checks++;
        if (obs_pair.size() < 1 || obs_pair[0] !== 2'b11) begin
            n_fail++; $display("FAIL new_frame_first: got %b want 11", (obs_pair.size() > 0) ? obs_pair[0] : 2'bxx);
        end
        // Drain the remaining tail symbols of the one-bit frame.
`ifdef CONV_ENC_TAIL_EN
        repeat (3) @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_backpressure;
        bits_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef CONV_ENC_TAIL_EN
        exp_pair = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_pair = '{2'b11, 2'b10, 2'b00, 2'b01};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
        exp_n = exp_pair.size();
        capture(2, 200);
        n_checks++;
        if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d bad stall cycles want 0", stall_bad); end
        n_checks++;
        if (obs_pair.size() != exp_n) begin
            n_fail++; $display("FAIL bp_count: got %0d symbols want %0d", obs_pair.size(), exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                n_checks++;
                if (obs_pair[i] !== exp_pair[i] || obs_last[i] !== exp_last[i]) begin
                    n_fail++;
                    $display("FAIL bp_sym%0d: got %b/%b want %b/%b", i, obs_pair[i], obs_last[i], exp_pair[i], exp_last[i]);
                end
            end
        end
        n_checks++;
        if (frame_pairs !== 16'(exp_n)) begin n_fail++; $display("FAIL bp_frame_pairs: got %0d want %0d", frame_pairs, exp_n); end
    endtask

    task automatic test_back_to_back;
        int exp_acc[$];
        int exp_fp;
        bits_q = '{1'b1, 1'b1, 1'b1};
        last_q = '{1'b1, 1'b0, 1'b1};
`ifdef CONV_ENC_TAIL_EN
        exp_pair = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11};
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_acc  = '{0, 3, 4};
        exp_fp   = 4;
`else
        exp_pair = '{2'b11, 2'b11, 2'b01};
        exp_last = '{1'b1, 1'b0, 1'b1};
        exp_acc  = '{0, 1, 2};
        exp_fp   = 2;
`endif
        exp_n = exp_pair.size();
        capture(0, 200);
        n_checks++;
        if (obs_pair.size() != exp_n) begin
            n_fail++; $display("FAIL b2b_count: got %0d symbols want %0d", obs_pair.size(), exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                n_checks++;
                if (obs_pair[i] !== exp_pair[i] || obs_last[i] !== exp_last[i] || obs_cyc[i] != i + 1) begin
                    n_fail++;
                    $display("FAIL b2b_sym%0d: got %b/%b cyc %0d want %b/%b cyc %0d",
                             i, obs_pair[i], obs_last[i], obs_cyc[i], exp_pair[i], exp_last[i], i + 1);
                end
            end
        end
        n_checks++;
        if (acc_cyc.size() != 3) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d accepts want 3", acc_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (acc_cyc[i] != exp_acc[i]) begin
                    n_fail++; $display("FAIL b2b_accept%0d: got cycle %0d want %0d", i, acc_cyc[i], exp_acc[i]);
                end
            end
        end
        n_checks++;
        if (frame_pairs !== 16'(exp_fp)) begin n_fail++; $display("FAIL b2b_frame_pairs: got %0d want %0d", frame_pairs, exp_fp); end
    endtask

    task automatic test_reset_mid_frame;
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_bit = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (frame_pairs !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_pairs: got %0d want 0", frame_pairs); end
        bits_q = '{1'b1};
        last_q = '{1'b1};
`ifdef CONV_ENC_TAIL_EN
        exp_n = 3;
`else
        exp_n = 1;
`endif
        capture(0, 50);
        n_checks++;
        if (obs_pair.size() < 1 || obs_pair[0] !== 2'b11) begin
            n_fail++; $display("FAIL midrst_first: got %b want 11", (obs_pair.size() > 0) ? obs_pair[0] : 2'bxx);
        end
        n_checks++;
        if (frame_pairs !== 16'(exp_n)) begin n_fail++; $display("FAIL midrst_frame_pairs2: got %0d want %0d", frame_pairs, exp_n); end
    endtask

    task automatic test_random_frames;
        int lens[3] = '{1000, 1, 1000};
        int p1, p2, u, errs, last_len;
        bits_q.delete(); last_q.delete(); exp_pair.delete(); exp_last.delete();
        for (int f = 0; f < 3; f++) begin
            p1 = 0; p2 = 0;
            for (int i = 0; i < lens[f]; i++) begin
                u = int'($urandom_range(0, 1));
                bits_q.push_back(1'(u));
                last_q.push_back(i == lens[f] - 1);
                exp_pair.push_back({1'(u ^ p1 ^ p2), 1'(u ^ p2)});
`ifdef CONV_ENC_TAIL_EN
                exp_last.push_back(1'b0);
`else
                exp_last.push_back(i == lens[f] - 1);
`endif
                p2 = p1; p1 = u;
            end
`ifdef CONV_ENC_TAIL_EN
            exp_pair.push_back({1'(p1 ^ p2), 1'(p2)});
            exp_last.push_back(1'b0);
            exp_pair.push_back({1'(p1), 1'b0} ^ {1'b0, 1'b0} | {1'b0, 1'(p1)});
            exp_last.push_back(1'b1);
`endif
        end
`ifdef CONV_ENC_TAIL_EN
        last_len = lens[2] + 2;
`else
        last_len = lens[2];
`endif
        exp_n = exp_pair.size();
        capture(1, 40000);
        n_checks++;
        if (obs_pair.size() != exp_n) begin
            n_fail++; $display("FAIL rand_count: got %0d symbols want %0d", obs_pair.size(), exp_n);
        end else begin
            errs = 0;
            for (int i = 0; i < exp_n; i++) begin
                if (obs_pair[i] !== exp_pair[i] || obs_last[i] !== exp_last[i]) begin
                    if (errs < 5)
                        $display("FAIL rand_sym%0d: got %b/%b want %b/%b", i, obs_pair[i], obs_last[i], exp_pair[i], exp_last[i]);
                    errs++;
                end
            end
            n_checks++;
            if (errs != 0) begin n_fail++; $display("FAIL rand_stream: got %0d wrong symbols want 0", errs); end
        end
        n_checks++;
        if (frame_pairs !== 16'(last_len)) begin n_fail++; $display("FAIL rand_frame_pairs: got %0d want %0d", frame_pairs, last_len); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
